// File: rtl/procik_pkg.sv
// procik_pkg: opcode/state enums and instruction field offsets for procik_core
package procik_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_LD, OP_ST, OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND,
    OP_OR, OP_XOR, OP_JMP, OP_JZ, OP_JNZ, OP_ILL_D, OP_ILL_E, OP_HALT
  } op_e;
  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_e;
  function automatic int op_lsb(int dw);
    return dw - 4;
  endfunction
  function automatic int ra_lsb(int dw, int rw);
    return dw - 4 - rw;
  endfunction
  function automatic int rb_lsb(int dw, int rw);
    return dw - 4 - 2 * rw;
  endfunction
endpackage

// File: rtl/procik_if.sv
// procik_if: word-addressed req/ready memory port with wait-state support
interface procik_if #(parameter int DATA_W = 16, parameter int ADDR_W = 8);
  logic mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/procik_regfile.sv
// procik_regfile: NREG x DATA_W registers, two async read ports, one sync write, sync active-low clear
module procik_regfile #(parameter int DATA_W = 16, parameter int NREG = 4) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      we,
  input  logic [$clog2(NREG)-1:0]   waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [$clog2(NREG)-1:0]   ra_addr,
  input  logic [$clog2(NREG)-1:0]   rb_addr,
  output logic [DATA_W-1:0]         ra_data,
  output logic [DATA_W-1:0]         rb_data
);
  logic [DATA_W-1:0] r [NREG];
  always_ff @(posedge clock)
    if (!reset) r <= '{default: '0};
    else if (we) r[waddr] <= wdata;
  assign ra_data = r[ra_addr];
  assign rb_data = r[rb_addr];
endmodule

// File: rtl/procik_core.sv
// procik_core: multi-cycle fetch/exec core with IP, IR, regfile and ALU on a req/ready memory port
module procik_core import procik_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NREG   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  procik_if.master          mem,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] ip
);
  localparam int RW = $clog2(NREG);
  localparam int OPL = op_lsb(DATA_W);
  localparam int RAL = ra_lsb(DATA_W, RW);
  localparam int RBL = rb_lsb(DATA_W, RW);
  state_e state, state_nxt;
  op_e op;
  logic [DATA_W-1:0] ir, ir_nxt, ra_d, rb_d, alu, wd;
  logic [ADDR_W-1:0] ip_nxt, imm;
  logic [RW-1:0] ra, rb;
  logic pend, rf_we, take, unused_ir;
  assign op = op_e'(ir[OPL +: 4]);
  assign ra = ir[RAL +: RW];
  assign rb = ir[RBL +: RW];
  assign imm = ir[ADDR_W-1:0];
  assign unused_ir = ^ir;
  assign halted = state == HALT;
  assign take = op == OP_JMP || (op == OP_JZ && ra_d == '0) || (op == OP_JNZ && ra_d != '0);
  assign alu = op == OP_LDI ? DATA_W'(imm) : op == OP_MOV ? rb_d : op == OP_ADD ? ra_d + rb_d :
               op == OP_SUB ? ra_d - rb_d : op == OP_AND ? ra_d & rb_d : op == OP_OR ? ra_d | rb_d : ra_d ^ rb_d;
  // pend keeps a started fetch request alive until ready, even if run drops
  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we = 1'b0;
    mem.mem_addr = '0;
    mem.mem_wdata = '0;
    if (reset && state == FETCH) begin
      mem.mem_req = run | pend;
      mem.mem_addr = ip;
    end else if (reset && state == MEM) begin
      mem.mem_req = 1'b1;
      mem.mem_we = op == OP_ST;
      mem.mem_addr = imm;
      mem.mem_wdata = ra_d;
    end
  end
  always_comb begin
    state_nxt = state;
    ip_nxt = ip;
    ir_nxt = ir;
    rf_we = 1'b0;
    wd = alu;
    case (state)
      FETCH: if (mem.mem_req && mem.mem_ready) begin
        ir_nxt = mem.mem_rdata;
        ip_nxt = ip + ADDR_W'(1);
        state_nxt = EXEC;
      end
      EXEC: begin
        rf_we = op inside {OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
        ip_nxt = take ? imm : ip;
        state_nxt = op inside {OP_LD, OP_ST} ? MEM : op inside {OP_HALT, OP_ILL_D, OP_ILL_E} ? HALT : FETCH;
      end
      MEM: if (mem.mem_ready) begin
        rf_we = op == OP_LD;
        wd = mem.mem_rdata;
        state_nxt = FETCH;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clock)
    if (!reset) begin
      state <= FETCH;
      ip <= '0;
      ir <= '0;
      pend <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      ip <= ip_nxt;
      ir <= ir_nxt;
      pend <= state == FETCH && mem.mem_req && !mem.mem_ready;
      illegal <= illegal | (state == EXEC && (op == OP_ILL_D || op == OP_ILL_E));
    end
  procik_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clock(clock), .reset(reset), .we(rf_we), .waddr(ra), .wdata(wd),
    .ra_addr(ra), .rb_addr(rb), .ra_data(ra_d), .rb_data(rb_d)
  );
endmodule

// File: tb/tb_procik_core.sv
// tb_procik_core: random and directed programs checked against an ISA-level model of procik_core
module tb_procik_core;
  logic clock = 0, reset = 0, run = 0;
  always #5 clock = ~clock;
  procik_if #(.DATA_W(16), .ADDR_W(8)) b0();
  procik_if #(.DATA_W(24), .ADDR_W(12)) b1();
  logic h0, i0, h1, i1;
  logic [7:0] ip0;
  logic [11:0] ip1;
  procik_core dut0 (.clock(clock), .reset(reset), .run(run), .mem(b0.master), .halted(h0), .illegal(i0), .ip(ip0));
  procik_core #(.DATA_W(24), .ADDR_W(12), .NREG(8)) dut1 (
    .clock(clock), .reset(reset), .run(run), .mem(b1.master), .halted(h1), .illegal(i1), .ip(ip1));
  logic [15:0] m0 [256];
  logic [23:0] m1 [4096];
  int waits [1024];
  int nreq = 0, wcnt = 0, sel = 0, hwa = 0, hwd = 0;
  int xf [$];
  logic clr = 0, hwe = 0;
  int n_chk = 0, n_pass = 0;
  assign b0.mem_ready = sel != 0 || wcnt >= waits[nreq % 1024];
  assign b0.mem_rdata = m0[b0.mem_addr];
  assign b1.mem_ready = 1'b1;
  assign b1.mem_rdata = m1[b1.mem_addr];
  always @(posedge clock) begin
    if (clr) begin
      foreach (m0[i]) m0[i] <= '0;
      foreach (m1[i]) m1[i] <= '0;
      nreq <= 0;
      wcnt <= 0;
      xf.delete();
    end else if (hwe) begin
      if (sel == 0) m0[hwa[7:0]] <= hwd[15:0];
      else m1[hwa[11:0]] <= hwd[23:0];
    end else if (!reset) wcnt <= 0;
    else if (sel == 0 && b0.mem_req) begin
      if (b0.mem_ready) begin
        if (b0.mem_we) m0[b0.mem_addr] <= b0.mem_wdata;
        xf.push_back((int'(b0.mem_we) << 16) | int'(b0.mem_addr));
        nreq <= nreq + 1;
        wcnt <= 0;
      end else wcnt <= wcnt + 1;
    end else if (sel == 1 && b1.mem_req) begin
      if (b1.mem_we) m1[b1.mem_addr] <= b1.mem_wdata;
      xf.push_back((int'(b1.mem_we) << 16) | int'(b1.mem_addr));
    end
  end
  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask
  // a stalled request must keep req, addr, we and wdata until ready
  logic sp = 0, s_we = 0;
  logic [7:0] s_addr = 0;
  logic [15:0] s_wd = 0;
  always @(negedge clock) begin
    if (reset && sp) begin
      check("stall_req", b0.mem_req, 1);
      check("stall_addr", b0.mem_addr, s_addr);
      check("stall_we", b0.mem_we, s_we);
      check("stall_wdata", b0.mem_wdata, s_wd);
    end
    sp = reset && sel == 0 && b0.mem_req && !b0.mem_ready;
    s_addr = b0.mem_addr;
    s_we = b0.mem_we;
    s_wd = b0.mem_wdata;
  end
  int dw, aw, rw, m_ip, m_ill;
  int mm [4096];
  int mx [$];
  int pa [$], pd [$];
  function automatic int enc(int op, int ra, int rb, int imm);
    return (op << (dw - 4)) | (ra << (dw - 4 - rw)) | (rb << (dw - 4 - 2 * rw)) | imm;
  endfunction
  task automatic put(input int a, input int d);
    pa.push_back(a);
    pd.push_back(d);
  endtask
  task automatic prog1();
    put(0, enc(3, 1, 0, 5));
    put(1, enc(3, 2, 0, 3));
    put(2, enc(5, 1, 2, 0));
    put(3, enc(2, 1, 0, 'h80));
    put(4, enc(15, 0, 0, 0));
  endtask
  // instruction-level reference: cycles = 2 per instruction (+1 for LD/ST) plus wait states
  task automatic model(output int cyc);
    int r [8];
    int ip = 0, w = 0, am = (1 << aw) - 1, dm = (1 << dw) - 1;
    int ir, op, ra, rb, imm;
    bit halt = 0;
    r = '{default: 0};
    cyc = 0;
    m_ill = 0;
    mx.delete();
    while (!halt && cyc < 5000) begin
      ir = mm[ip];
      mx.push_back(ip);
      cyc += 2 + waits[w % 1024];
      w++;
      ip = (ip + 1) & am;
      op = (ir >> (dw - 4)) & 15;
      ra = (ir >> (dw - 4 - rw)) & ((1 << rw) - 1);
      rb = (ir >> (dw - 4 - 2 * rw)) & ((1 << rw) - 1);
      imm = ir & am;
      case (op)
        1: begin mx.push_back(imm); cyc += 1 + waits[w % 1024]; w++; r[ra] = mm[imm]; end
        2: begin mx.push_back(65536 | imm); cyc += 1 + waits[w % 1024]; w++; mm[imm] = r[ra]; end
        3: r[ra] = imm;
        4: r[ra] = r[rb];
        5: r[ra] = (r[ra] + r[rb]) & dm;
        6: r[ra] = (r[ra] - r[rb]) & dm;
        7: r[ra] = r[ra] & r[rb];
        8: r[ra] = r[ra] | r[rb];
        9: r[ra] = r[ra] ^ r[rb];
        10: ip = imm;
        11: if (r[ra] == 0) ip = imm;
        12: if (r[ra] != 0) ip = imm;
        13, 14: begin halt = 1; m_ill = 1; end
        15: halt = 1;
        default: ;
      endcase
    end
    m_ip = ip;
  endtask
  task automatic load();
    reset = 0;
    run = 0;
    clr = 1;
    @(posedge clock);
    #1 clr = 0;
    for (int i = 0; i < 4096; i++) mm[i] = 0;
    hwe = 1;
    for (int i = 0; i < pa.size(); i++) begin
      hwa = pa[i];
      hwd = pd[i];
      mm[pa[i]] = pd[i];
      @(posedge clock);
      #1;
    end
    hwe = 0;
    pa.delete();
    pd.delete();
  endtask
  task automatic run_dut(input bit rnd, output int cyc);
    int nr = 0;
    @(negedge clock);
    reset = 1;
    run = 1;
    cyc = 0;
    while (!(sel == 0 ? h0 : h1) && cyc < 5000) begin
      @(posedge clock);
      #1 cyc++;
      if (rnd) run = 1'($urandom_range(0, 1));
    end
    check("halted", sel == 0 ? h0 : h1, 1);
    run = 1;
    repeat (8) @(negedge clock) nr += int'(sel == 0 ? b0.mem_req : b1.mem_req);
    check("halt_noreq", nr, 0);
  endtask
  task automatic compare(input string tag);
    int bad = 0;
    check({tag, "_xfers"}, xf.size(), mx.size());
    for (int i = 0; i < xf.size() && i < mx.size(); i++) check({tag, "_xfer"}, xf[i], mx[i]);
    for (int i = 0; i < (1 << aw); i++)
      bad += int'((sel == 0 ? 32'(m0[i % 256]) : 32'(m1[i])) != mm[i]);
    check({tag, "_mem"}, bad, 0);
    check({tag, "_ip"}, sel == 0 ? ip0 : ip1, m_ip);
    check({tag, "_illegal"}, sel == 0 ? i0 : i1, m_ill);
  endtask
  initial begin
    int mc, dc, n, op, imm;
    int ops [9];
    ops = '{0, 1, 3, 4, 5, 6, 7, 8, 9};
    dw = 16;
    aw = 8;
    rw = 2;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req", b0.mem_req, 0);
    check("rst_we", b0.mem_we, 0);
    check("rst_addr", b0.mem_addr, 0);
    check("rst_wdata", b0.mem_wdata, 0);
    check("rst_halted", h0, 0);
    check("rst_illegal", i0, 0);
    check("rst_ip", ip0, 0);
    prog1(); load(); model(mc); run_dut(0, dc);
    check("p1_cycles", dc, mc);
    check("p1_cycles_abs", dc, 11);
    check("p1_m80", m0[128], 8);
    compare("p1");
    foreach (waits[i]) waits[i] = 3;
    prog1(); load(); model(mc); run_dut(0, dc);
    check("stall_cycles", dc, mc);
    check("stall_m80", m0[128], 8);
    compare("stall");
    foreach (waits[i]) waits[i] = 0;
    put(0, enc(3, 1, 0, 1)); put(1, enc(3, 0, 0, 3)); put(2, enc(6, 0, 1, 0));
    put(3, enc(12, 0, 0, 2)); put(4, enc(15, 0, 0, 0));
    load(); model(mc); run_dut(0, dc);
    n = 0;
    foreach (xf[i]) n += int'(xf[i] == 2);
    check("loop_subs", n, 3);
    compare("loop");
    put(0, enc(12, 1, 0, 'h10)); put(1, enc(3, 1, 0, 1)); put(2, enc(10, 0, 0, 'hFF));
    put('hFF, 0); put('h10, enc(15, 0, 0, 0));
    load(); model(mc); run_dut(0, dc);
    n = -1;
    foreach (xf[i]) if (xf[i] == 'hFF && n < 0) n = i;
    check("wrap_next", (n >= 0 && n + 1 < xf.size()) ? xf[n + 1] : -1, 0);
    compare("wrap");
    put(0, enc(3, 0, 0, 7)); put(1, enc(13, 0, 0, 0));
    load(); model(mc); run_dut(0, dc);
    check("ill_flag", i0, 1);
    compare("ill");
    repeat (10) @(negedge clock);
    check("ill_sticky", i0, 1);
    waits[2] = 20;
    put(0, enc(3, 2, 0, 9)); put(1, enc(2, 2, 0, 'h40)); put(2, enc(15, 0, 0, 0));
    load();
    check("ill_cleared", i0, 0);
    check("halt_cleared", h0, 0);
    @(negedge clock);
    reset = 1;
    run = 1;
    n = 0;
    while (!(b0.mem_req && b0.mem_we) && n < 100) begin @(negedge clock); n++; end
    check("st_pending", b0.mem_req && b0.mem_we, 1);
    @(negedge clock);
    reset = 0;
    @(posedge clock);
    #1;
    check("abandon_req", b0.mem_req, 0);
    check("abandon_ip", ip0, 0);
    check("abandon_m40", m0[64], 0);
    @(negedge clock);
    reset = 1;
    #1;
    check("refetch_req", b0.mem_req, 1);
    check("refetch_addr", b0.mem_addr, 0);
    waits[2] = 0;
    put(0, enc(2, 2, 0, 'h41)); put(1, enc(15, 0, 0, 0)); put('h41, 'h5555);
    load(); model(mc); run_dut(0, dc);
    check("clr_reg", m0[65], 0);
    compare("post_rst");
    for (int it = 0; it < 6; it++) begin
      foreach (waits[i]) waits[i] = $urandom_range(0, 2);
      for (int k = 0; k < 12; k++) begin
        op = ops[$urandom_range(0, 8)];
        imm = op == 1 ? 'h90 + $urandom_range(0, 15) : op == 3 ? $urandom_range(0, 255) : 0;
        put(k, enc(op, $urandom_range(0, 3), $urandom_range(0, 3), imm));
      end
      for (int k = 0; k < 4; k++) put(12 + k, enc(2, k, 0, 'h80 + k));
      put(16, enc(15, 0, 0, 0));
      for (int k = 0; k < 16; k++) put('h90 + k, $urandom_range(0, 65535));
      load(); model(mc); run_dut(it == 5, dc);
      if (it != 5) check("rnd_cycles", dc, mc);
      compare("rnd");
    end
    sel = 1;
    dw = 24;
    aw = 12;
    rw = 3;
    foreach (waits[i]) waits[i] = 0;
    prog1(); load(); model(mc); run_dut(0, dc);
    check("wide_cycles", dc, mc);
    check("wide_cycles_abs", dc, 11);
    check("wide_m80", m1[128], 8);
    compare("wide");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
